// File: rtl/pll_reconfig_pkg.sv
// Shared constants, register field positions and FSM types for the PLL reconfig master.
package pll_reconfig_pkg;

  localparam logic [5:0] ADDR_MODE   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] ADDR_START  = 6'h02;
  localparam logic [5:0] ADDR_N      = 6'h03;
  localparam logic [5:0] ADDR_M      = 6'h04;
  localparam logic [5:0] ADDR_C      = 6'h05;

  localparam int unsigned HI_LSB   = 8;
  localparam int unsigned BYP_BIT  = 16;
  localparam int unsigned ODD_BIT  = 17;
  localparam int unsigned CSEL_LSB = 18;
  localparam int unsigned WORD_W   = 18;
  localparam int unsigned DIV_MAX  = 510;

  typedef enum logic [2:0] {
    StIdle,
    StChk,
    StWrMode,
    StWrN,
    StWrM,
    StWrC,
    StWrStart,
    StWaitLock
  } state_e;

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrIllegal = 2'd1,
    ErrTimeout = 2'd2
  } err_code_e;

  function automatic logic [5:0] wr_addr(state_e st);
    case (st)
      StWrN:     return ADDR_N;
      StWrM:     return ADDR_M;
      StWrC:     return ADDR_C;
      StWrStart: return ADDR_START;
      default:   return ADDR_MODE;
    endcase
  endfunction

endpackage

// File: rtl/pll_reconfig_if.sv
// Avalon-MM link between the reconfig master and the PLL reconfig management slave.
interface pll_reconfig_if;
  logic [5:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic        waitrequest;

  modport master (
    output address,
    output write,
    output read,
    output writedata,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  write,
    input  read,
    input  writedata,
    output waitrequest
  );
endinterface

// File: rtl/pll_div_encode.sv
// Encodes one divide value into the reconfig counter word (bypass, high/low counts, odd bit).
module pll_div_encode
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned DIV_W = 9
) (
  input  logic [DIV_W-1:0]  div,
  output logic              legal,
  output logic [WORD_W-1:0] word
);

  logic [31:0] dv;

  always_comb begin
    dv    = 32'(div);
    legal = (dv != 32'd0) && (dv <= DIV_MAX);
    word  = '0;
    if (dv == 32'd1) begin
      word[BYP_BIT] = 1'b1;
    end else begin
      // Odd values put the extra cycle in the high phase.
      word[HI_LSB +: 8] = 8'((dv + 32'd1) >> 1);
      word[7:0]         = 8'(dv >> 1);
      word[ODD_BIT]     = dv[0];
    end
  end

endmodule

// File: rtl/pll_reconfig_master.sv
// Avalon-MM initiator: encodes one divider set, writes the PLL reconfig registers,
// starts reconfiguration and waits for lock (or a timeout).
module pll_reconfig_master
  import pll_reconfig_pkg::*;
#(
  parameter int unsigned DIV_W        = 9,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_n,
  input  logic [DIV_W-1:0] cfg_m,
  input  logic [DIV_W-1:0] cfg_c,
  input  logic [4:0]       cfg_c_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  pll_reconfig_if.master   avm,
  input  logic             pll_locked
);

  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  n_q, m_q, c_q;
  logic [4:0]        csel_q;
  logic [1:0]        sync_q;
  logic              done_q, done_d, err_q, err_d;
  err_code_e         err_code_q, err_code_d;

  logic              accept, locked_s, timeout, all_legal;
  logic              n_legal, m_legal, c_legal;
  logic [WORD_W-1:0] n_word, m_word, c_word;

  assign accept    = cfg_valid && (state_q == StIdle);
  assign locked_s  = sync_q[1];
  assign timeout   = (32'(cnt_q) + 32'd1) >= LOCK_TIMEOUT;
  assign all_legal = n_legal && m_legal && c_legal;

  pll_div_encode #(.DIV_W(DIV_W)) u_enc_n (.div(n_q), .legal(n_legal), .word(n_word));
  pll_div_encode #(.DIV_W(DIV_W)) u_enc_m (.div(m_q), .legal(m_legal), .word(m_word));
  pll_div_encode #(.DIV_W(DIV_W)) u_enc_c (.div(c_q), .legal(c_legal), .word(c_word));

  // Request capture and pll_locked synchroniser.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_q <= '0;
      n_q    <= '0;
      m_q    <= '0;
      c_q    <= '0;
      csel_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
      if (accept) begin
        n_q    <= cfg_n;
        m_q    <= cfg_m;
        c_q    <= cfg_c;
        csel_q <= cfg_c_sel;
      end
    end
  end

  // State register; done/err/err_code are registered so they align with the return to idle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      StIdle:     if (accept) state_d = StChk;
      StChk:      state_d = all_legal ? StWrMode : StIdle;
      StWrMode:   if (!avm.waitrequest) state_d = StWrN;
      StWrN:      if (!avm.waitrequest) state_d = StWrM;
      StWrM:      if (!avm.waitrequest) state_d = StWrC;
      StWrC:      if (!avm.waitrequest) state_d = StWrStart;
      StWrStart:  if (!avm.waitrequest) state_d = StWaitLock;
      StWaitLock: begin
        cnt_d = cnt_q + 1'b1;
        if (locked_s || timeout) state_d = StIdle;
      end
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    avm.write     = 1'b0;
    avm.read      = 1'b0;
    avm.address   = '0;
    avm.writedata = '0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    cfg_ready     = (state_q == StIdle);
    busy          = (state_q != StIdle);
    case (state_q)
      StIdle: if (accept) err_code_d = ErrNone;
      StChk: begin
        if (!all_legal) begin
          err_d      = 1'b1;
          err_code_d = ErrIllegal;
        end
      end
      StWrMode, StWrN, StWrM, StWrC, StWrStart: begin
        avm.write   = 1'b1;
        avm.address = wr_addr(state_q);
        case (state_q)
          StWrN:     avm.writedata = 32'(n_word);
          StWrM:     avm.writedata = 32'(m_word);
          StWrC:     avm.writedata = 32'(c_word) | (32'(csel_q) << CSEL_LSB);
          StWrStart: avm.writedata = 32'd1;
          default:   avm.writedata = 32'd0;
        endcase
      end
      StWaitLock: begin
        // Lock wins over a coincident timeout.
        if (locked_s) begin
          done_d = 1'b1;
        end else if (timeout) begin
          err_d      = 1'b1;
          err_code_d = ErrTimeout;
        end
      end
      default: ;
    endcase
  end

  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_pll_reconfig_master.sv
// Scoreboard bench for pll_reconfig_master: expected bus writes are queued at request time.
module tb_pll_reconfig_master;

  localparam int unsigned DIV_W        = 9;
  localparam int unsigned LOCK_TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_n = '0, cfg_m = '0, cfg_c = '0;
  logic [4:0]       cfg_c_sel = '0;
  logic             busy, done, err;
  logic [1:0]       err_code;
  logic             pll_locked = 1'b0;
  logic             wreq = 1'b0;

  pll_reconfig_if avm ();
  assign avm.waitrequest = wreq;

  pll_reconfig_master #(
    .DIV_W       (DIV_W),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_n        (cfg_n),
    .cfg_m        (cfg_m),
    .cfg_c        (cfg_c),
    .cfg_c_sel    (cfg_c_sel),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .avm          (avm),
    .pll_locked   (pll_locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [37:0] wr_q[$];
  int          ws_stall = 0;
  int          stall_cnt = 0;
  bit          hold_m = 1'b0;
  int          lock_delay = 0;
  int          lock_at = -1;
  int          accept_cyc = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(int unsigned d);
    if (d == 1) return 32'h0001_0000;
    return 32'((((d + 1) / 2) << 8) | (d / 2) | ((d % 2) << 17));
  endfunction

  // Slave model: stall each write ws_stall cycles; hold_m stalls the M write forever.
  always @(posedge clk) begin
    #1;
    if (hold_m && avm.write && avm.address == 6'h04) begin
      wreq = 1'b1;
    end else if (avm.write && stall_cnt < ws_stall) begin
      wreq = 1'b1;
      stall_cnt++;
    end else begin
      wreq = 1'b0;
      stall_cnt = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (lock_at >= 0 && cyc >= lock_at) pll_locked = 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n && avm.write) begin
      chk("avm_read", avm.read, 0);
      if (wr_q.size() == 0) begin
        chk("write_when_none_expected", avm.write, 0);
      end else begin
        chk("wr_addr", avm.address, wr_q[0][37:32]);
        chk("wr_data", avm.writedata, wr_q[0][31:0]);
        if (!wreq) begin
          if (wr_q[0][37:32] == 6'h02) lock_at = (lock_delay < 0) ? -1 : cyc + 1 + lock_delay;
          void'(wr_q.pop_front());
        end
      end
    end
  end

  task automatic run_cfg(int unsigned n, int unsigned m, int unsigned csel, int unsigned c);
    bit legal;
    legal = (n >= 1 && n <= 510) && (m >= 1 && m <= 510) && (c >= 1 && c <= 510);
    @(negedge clk);
    chk("ready_idle", cfg_ready, 1);
    cfg_n      = 9'(n);
    cfg_m      = 9'(m);
    cfg_c      = 9'(c);
    cfg_c_sel  = 5'(csel);
    cfg_valid  = 1'b1;
    pll_locked = 1'b0;
    lock_at    = -1;
    if (legal) begin
      wr_q.push_back({6'h00, 32'h0});
      wr_q.push_back({6'h03, enc(n)});
      wr_q.push_back({6'h04, enc(m)});
      wr_q.push_back({6'h05, enc(c) | (32'(csel) << 18)});
      wr_q.push_back({6'h02, 32'h1});
    end
    @(posedge clk);
    #1;
    cfg_valid  = 1'b0;
    accept_cyc = cyc;
    chk("busy_on_accept", busy, 1);
    chk("code_clear_on_accept", err_code, 0);
    cfg_n     = 9'($urandom);
    cfg_m     = 9'($urandom);
    cfg_c     = 9'($urandom);
    cfg_c_sel = 5'($urandom);
  endtask

  task automatic wait_result(string tag, logic exp_done, logic [1:0] exp_code, int exp_lat);
    bit   seen;
    logic busy_prev;
    seen = 1'b0;
    busy_prev = busy;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done || err) seen = 1'b1;
      else busy_prev = busy;
    end
    if (!seen) begin
      chk({tag, "_no_result"}, 0, 1);
      return;
    end
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_err"}, err, !exp_done);
    chk({tag, "_code"}, err_code, exp_code);
    chk({tag, "_latency"}, cyc - accept_cyc, exp_lat);
    chk({tag, "_busy_before"}, busy_prev, 1);
    chk({tag, "_busy_dropped"}, busy, 0);
    chk({tag, "_ready"}, cfg_ready, 1);
    chk({tag, "_writes_left"}, wr_q.size(), 0);
    @(negedge clk);
    chk({tag, "_pulse_end"}, done | err, 0);
    chk({tag, "_code_hold"}, err_code, exp_code);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_write", avm.write, 0);
    chk("rst_read", avm.read, 0);
    chk("rst_addr", avm.address, 0);
    chk("rst_wdata", avm.writedata, 0);
    rst_n = 1'b1;

    // Nominal set, no stalls: minimum latency.
    run_cfg(1, 12, 2, 5);
    wait_result("t1", 1'b1, 2'd0, 9);
    run_cfg(510, 2, 31, 3);
    wait_result("t1_max", 1'b1, 2'd0, 9);

    // Three stall cycles on every write.
    ws_stall = 3;
    run_cfg(4, 7, 1, 9);
    wait_result("t2", 1'b1, 2'd0, 24);
    ws_stall = 0;

    // Illegal dividers: no bus traffic.
    run_cfg(3, 3, 0, 0);
    wait_result("t3_c0", 1'b0, 2'd1, 1);
    run_cfg(3, 511, 0, 3);
    wait_result("t3_m511", 1'b0, 2'd1, 1);

    // Lock never arrives.
    lock_delay = -1;
    run_cfg(2, 2, 0, 2);
    wait_result("t4", 1'b0, 2'd2, 22);

    // Reset while the M write is stalled, then replay.
    lock_delay = 0;
    hold_m = 1'b1;
    run_cfg(5, 6, 3, 7);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (avm.write && avm.address == 6'h04) found = 1'b1;
    end
    chk("t5_reached_wr_m", found, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_write_drop", avm.write, 0);
    chk("t5_busy_drop", busy, 0);
    chk("t5_ready", cfg_ready, 1);
    wr_q.delete();
    hold_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_cfg(5, 6, 3, 7);
    wait_result("t5_replay", 1'b1, 2'd0, 9);

    // Request while busy is ignored; lock coincides with the timeout.
    lock_delay = 13;
    run_cfg(6, 8, 4, 10);
    repeat (2) @(negedge clk);
    cfg_valid = 1'b1;
    cfg_n     = 9'd1;
    cfg_m     = 9'd1;
    cfg_c     = 9'd1;
    chk("t6_ready_busy", cfg_ready, 0);
    @(negedge clk);
    chk("t6_busy", busy, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_result("t6", 1'b1, 2'd0, 22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
